// File: rtl/block_ram_arb_pkg.sv
// -----------------------------------------------------------------------------
// block_ram_arb_pkg
// Shared types and constants for the two-port block RAM arbiter.
//   port_id_e     : requester identity (PORT_A = 0, PORT_B = 1)
//   read_tag_t    : {valid, port} travelling alongside each RAM command
//   READ_LATENCY  : accept edge to response window, in clock edges
//   TAG_STAGES    : depth of the read-tag pipe (one stage per latency edge)
// Build option: BLOCK_RAM_ARB_OUTREG_EN selects the RAM output register path
// (latency 3, data from Regdouta); when undefined, latency is 2 from douta.
// -----------------------------------------------------------------------------
package block_ram_arb_pkg;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_id_e;

    typedef struct packed {
        logic     valid;
        port_id_e port;
    } read_tag_t;

`ifdef BLOCK_RAM_ARB_OUTREG_EN
    localparam int READ_LATENCY = 3;
`else
    localparam int READ_LATENCY = 2;
`endif

    localparam int TAG_STAGES = READ_LATENCY;

    // The port that should win the next tie after 'p' has been served.
    function automatic port_id_e other_port(input port_id_e p);
        return (p == PORT_A) ? PORT_B : PORT_A;
    endfunction

endpackage

// File: rtl/block_ram_arb_rr.sv
// -----------------------------------------------------------------------------
// block_ram_arb_rr
// Two-way round-robin grant generator.
//   clk      in   clock
//   reset_n  in   asynchronous active-low reset (tie priority returns to A)
//   valid    in   [1:0] request present, bit 0 = A, bit 1 = B
//   accept   in   a granted request was taken at this edge
//   grant    out  [1:0] one-hot (or zero) grant, purely combinational
//   prio     out  port that wins the next tie
// -----------------------------------------------------------------------------
module block_ram_arb_rr
    import block_ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant,
    output port_id_e   prio
);

    port_id_e prio_reg;
    port_id_e prio_next;

    // Grant depends only on the valids and the tie pointer, so neither
    // requester's ready ever loops through the other's ready.
    always_comb begin
        grant    = 2'b00;
        grant[0] = valid[0] && (!valid[1] || (prio_reg == PORT_A));
        grant[1] = valid[1] && (!valid[0] || (prio_reg == PORT_B));
    end

    always_comb begin
        prio_next = prio_reg;
        if (accept) begin
            prio_next = other_port(grant[1] ? PORT_B : PORT_A);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio_reg <= PORT_A;
        end else begin
            prio_reg <= prio_next;
        end
    end

    assign prio = prio_reg;

endmodule

// File: rtl/block_ram_arbiter.sv
// -----------------------------------------------------------------------------
// block_ram_arbiter
// Round-robin arbiter/sequencer sharing one single-port block RAM between two
// valid/ready requesters. RAM pins are driven from registers; read data is
// steered back to the issuing port using a tag pipe matched to RAM latency.
//   clk, reset_n                   clock (also RAM clka), async active-low reset
//   a_/b_valid, a_/b_ready         request handshake (ready is combinational)
//   a_/b_we, a_/b_addr, a_/b_wdata request contents
//   a_/b_rvalid, a_/b_rdata        read response, one-cycle pulse, no backpressure
//   ram_ena/wea/addra/dina/regcea  to RAM
//   ram_douta, ram_regdouta        from RAM
// Build option: BLOCK_RAM_ARB_OUTREG_EN uses the RAM output register
// (regcea pulse, data from Regdouta, latency 3). Default: latency 2 from douta.
// -----------------------------------------------------------------------------
module block_ram_arbiter
    import block_ram_arb_pkg::*;
#(
    parameter int AddrWidth = 12,
    parameter int DataWidth = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic                 a_we,
    input  logic [AddrWidth-1:0] a_addr,
    input  logic [DataWidth-1:0] a_wdata,
    output logic                 a_rvalid,
    output logic [DataWidth-1:0] a_rdata,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic                 b_we,
    input  logic [AddrWidth-1:0] b_addr,
    input  logic [DataWidth-1:0] b_wdata,
    output logic                 b_rvalid,
    output logic [DataWidth-1:0] b_rdata,
    output logic                 ram_ena,
    output logic                 ram_wea,
    output logic [AddrWidth-1:0] ram_addra,
    output logic [DataWidth-1:0] ram_dina,
    output logic                 ram_regcea,
    input  logic [DataWidth-1:0] ram_douta,
    input  logic [DataWidth-1:0] ram_regdouta
);

    // ---------------------------------------------------------------- arbiter
    logic [1:0] req_valid;
    logic [1:0] grant;
    logic       accept;
    port_id_e   prio_unused;   // tie pointer, only of interest when debugging

    assign req_valid = {b_valid, a_valid};
    assign accept    = |(req_valid & grant);
    assign a_ready   = grant[0];
    assign b_ready   = grant[1];

    block_ram_arb_rr u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .valid   (req_valid),
        .accept  (accept),
        .grant   (grant),
        .prio    (prio_unused)
    );

    // --------------------------------------------------------- command stage
    port_id_e             sel_port;
    logic                 sel_we;
    logic [AddrWidth-1:0] sel_addr;
    logic [DataWidth-1:0] sel_wdata;

    logic                 ena_reg,  ena_next;
    logic                 wea_reg,  wea_next;
    logic [AddrWidth-1:0] addr_reg, addr_next;
    logic [DataWidth-1:0] dina_reg, dina_next;
    read_tag_t            tag_next;

    always_comb begin
        sel_port  = grant[1] ? PORT_B : PORT_A;
        sel_we    = (sel_port == PORT_B) ? b_we    : a_we;
        sel_addr  = (sel_port == PORT_B) ? b_addr  : a_addr;
        sel_wdata = (sel_port == PORT_B) ? b_wdata : a_wdata;

        ena_next  = accept;
        wea_next  = accept && sel_we;
        // Address/data hold while idle so the RAM pins do not toggle needlessly.
        addr_next = accept ? sel_addr  : addr_reg;
        dina_next = accept ? sel_wdata : dina_reg;

        // Only reads expect a response; writes carry an empty tag.
        tag_next.valid = accept && !sel_we;
        tag_next.port  = sel_port;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ena_reg  <= 1'b0;
            wea_reg  <= 1'b0;
            addr_reg <= '0;
            dina_reg <= '0;
        end else begin
            ena_reg  <= ena_next;
            wea_reg  <= wea_next;
            addr_reg <= addr_next;
            dina_reg <= dina_next;
        end
    end

    assign ram_ena   = ena_reg;
    assign ram_wea   = wea_reg;
    assign ram_addra = addr_reg;
    assign ram_dina  = dina_reg;

    // -------------------------------------------------------------- tag pipe
    // Stage 0 lines up with the command register, the last stage with the
    // cycle in which the RAM data is presented to the requester.
    read_tag_t tag_pipe [TAG_STAGES];

    generate
        for (genvar gi = 0; gi < TAG_STAGES; gi++) begin : g_tag_stage
            read_tag_t stage_in;
            read_tag_t stage_reg;

            if (gi == 0) begin : g_head
                assign stage_in = tag_next;
            end else begin : g_body
                assign stage_in = tag_pipe[gi-1];
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    stage_reg <= '0;
                end else begin
                    stage_reg <= stage_in;
                end
            end

            assign tag_pipe[gi] = stage_reg;
        end
    endgenerate

    // ------------------------------------------------------- response demux
    logic [DataWidth-1:0] rd_data;
    read_tag_t            resp_tag;

`ifdef BLOCK_RAM_ARB_OUTREG_EN
    logic unused_douta;
    // Output register loads the cycle after the RAM array is read.
    assign ram_regcea  = tag_pipe[1].valid;
    assign rd_data     = ram_regdouta;
    assign unused_douta = ^ram_douta;
`else
    logic unused_regdouta;
    assign ram_regcea      = 1'b0;
    assign rd_data         = ram_douta;
    assign unused_regdouta = ^ram_regdouta;
`endif

    assign resp_tag = tag_pipe[TAG_STAGES-1];
    assign a_rvalid = resp_tag.valid && (resp_tag.port == PORT_A);
    assign b_rvalid = resp_tag.valid && (resp_tag.port == PORT_B);

    // RAM data only exists during the response cycle, so it is passed through
    // combinationally and captured for the hold value seen afterwards.
    logic [DataWidth-1:0] a_rdata_reg;
    logic [DataWidth-1:0] b_rdata_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_rdata_reg <= '0;
            b_rdata_reg <= '0;
        end else begin
            if (a_rvalid) a_rdata_reg <= rd_data;
            if (b_rvalid) b_rdata_reg <= rd_data;
        end
    end

    assign a_rdata = a_rvalid ? rd_data : a_rdata_reg;
    assign b_rdata = b_rvalid ? rd_data : b_rdata_reg;

endmodule
